// File: rtl/arrow_move.sv
// arrow_move: moves the player's arrow.
//   A fire key press launches the arrow from above the character. The arrow
//   then climbs ARROW_SPEED pixels per video frame until it hits a bubble,
//   hits the top border or runs out of screen. A short cooldown follows
//   before the next shot is accepted.
//
// Ports:
//   clk            system (pixel) clock
//   resetN         asynchronous active-low reset
//   startOfFrame   one-cycle pulse per video frame; all motion happens here
//   fireKey        fire key level, synchronous to clk
//   charX          character top-left X
//   arrowHitTop    collision: arrow drawn on the top border this frame
//   arrowHitBubble collision: arrow overlaps a bubble this frame
//   arrowX/arrowY  arrow top-left position (registered)
//   arrowActive    arrow in flight; gates the arrow draw request
//   arrowPopPulse  one-cycle pulse when the arrow pops a bubble
module arrow_move #(
   parameter int ARROW_X_OFFSET  = 16,
   parameter int ARROW_START_Y   = 400,
   parameter int ARROW_SPEED     = 8,
   parameter int X_MAX           = 639,
   parameter int COOLDOWN_FRAMES = 4
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        fireKey,
   input  logic [10:0] charX,
   input  logic        arrowHitTop,
   input  logic        arrowHitBubble,
   output logic [10:0] arrowX,
   output logic [10:0] arrowY,
   output logic        arrowActive,
   output logic        arrowPopPulse
);

   typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

   state_t      state, state_n;
   logic [10:0] x_n, y_n;
   logic        act_n, pop_n;
   logic [3:0]  cnt, cnt_n;

   logic        fire_d;     // fireKey history
   logic        key_armed;  // fireKey has been seen low since reset
   logic        fire_req;
   logic        hit_top_f, hit_bub_f;

   logic        fire_rise;
   logic        hit_top_m, hit_bub_m;
   logic [11:0] x_sum;
   logic [10:0] x_launch;

   // A key held through reset release must not count as a press, so an
   // edge only qualifies once the key has been observed released.
   assign fire_rise = fireKey & ~fire_d & key_armed;

   // Collision alerts only matter while the arrow is in flight.
   assign hit_top_m = arrowHitTop    & (state == FLYING);
   assign hit_bub_m = arrowHitBubble & (state == FLYING);

   // Sum at 12 bits so a charX near the right edge clamps instead of wrapping.
   assign x_sum    = {1'b0, charX} + 12'(ARROW_X_OFFSET);
   assign x_launch = (x_sum > 12'(X_MAX)) ? 11'(X_MAX) : x_sum[10:0];

   // Fire edge and sticky hit flags. The flags restart at each frame so a
   // decision at startOfFrame sees only the hits of the frame just ended;
   // a hit coinciding with startOfFrame lands in the new frame.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         fire_d    <= 1'b0;
         key_armed <= 1'b0;
         fire_req  <= 1'b0;
         hit_top_f <= 1'b0;
         hit_bub_f <= 1'b0;
      end else begin
         fire_d <= fireKey;
         if (!fireKey)
            key_armed <= 1'b1;

         if (state != IDLE)
            fire_req <= 1'b0;              // presses during flight/cooldown are dropped
         else if (startOfFrame && fire_req)
            fire_req <= 1'b0;              // consumed by this frame's launch
         else
            fire_req <= fire_req | fire_rise;

         hit_top_f <= startOfFrame ? hit_top_m : (hit_top_f | hit_top_m);
         hit_bub_f <= startOfFrame ? hit_bub_m : (hit_bub_f | hit_bub_m);
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state         <= IDLE;
         arrowX        <= '0;
         arrowY        <= 11'(ARROW_START_Y);
         arrowActive   <= 1'b0;
         arrowPopPulse <= 1'b0;
         cnt           <= '0;
      end else begin
         state         <= state_n;
         arrowX        <= x_n;
         arrowY        <= y_n;
         arrowActive   <= act_n;
         arrowPopPulse <= pop_n;
         cnt           <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      x_n     = arrowX;
      y_n     = arrowY;
      act_n   = arrowActive;
      pop_n   = 1'b0;
      cnt_n   = cnt;
      if (startOfFrame) begin
         case (state)
            IDLE: begin
               if (fire_req) begin
                  x_n     = x_launch;
                  y_n     = 11'(ARROW_START_Y);
                  act_n   = 1'b1;
                  state_n = FLYING;
               end
            end
            FLYING: begin
               // Bubble beats top border so a double hit pops exactly once.
               if (hit_bub_f) begin
                  pop_n   = 1'b1;
                  act_n   = 1'b0;
                  cnt_n   = 4'(COOLDOWN_FRAMES);
                  state_n = COOLDOWN;
               end else if (hit_top_f || (arrowY < 11'(ARROW_SPEED))) begin
                  act_n   = 1'b0;
                  cnt_n   = 4'(COOLDOWN_FRAMES);
                  state_n = COOLDOWN;
               end else begin
                  y_n = arrowY - 11'(ARROW_SPEED);
               end
            end
            COOLDOWN: begin
               if (cnt <= 4'd1) begin
                  cnt_n   = '0;
                  y_n     = 11'(ARROW_START_Y);
                  state_n = IDLE;
               end else begin
                  cnt_n = cnt - 4'd1;
               end
            end
            default: begin
               act_n   = 1'b0;
               cnt_n   = '0;
               state_n = IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/arrow_move.md
Name: arrow_move

Overview:
- Moving logic for the player's arrow: the consumer of the arrow collision alerts raised by the collision/border logic.
- Launches an arrow from the character on a fire key press and advances it upward once per frame.
- Ends the flight on a top-border hit or a bubble hit, and reports bubble pops to the bubble logic.
- Sits between the keypad/character logic and the arrow drawing object; its arrowX/arrowY feed the arrow drawer, whose draw request closes the loop through collision detection.

Parameters:
- ARROW_X_OFFSET, 16, pixels added to charX to centre the arrow on the character.
- ARROW_START_Y, 400, arrow top-left Y at launch.
- ARROW_SPEED, 8, pixels moved upward per frame.
- X_MAX, 639, largest legal arrowX; launch X is clamped to this value.
- COOLDOWN_FRAMES, 4, frames after flight ends before a new shot is accepted; range 1..15.

Ports:
- clk  in  1  system clock (pixel clock domain)
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- fireKey  in  1  fire key level, already synchronous to clk
- charX  in  11  character top-left X
- arrowHitTop  in  1  from collision logic; arrow drawn on top border this frame
- arrowHitBubble  in  1  from collision logic; arrow and bubble drawn on the same pixel this frame
- arrowX  out  11  arrow top-left X
- arrowY  out  11  arrow top-left Y
- arrowActive  out  1  arrow in flight; gates the arrow draw request
- arrowPopPulse  out  1  one-cycle pulse: arrow popped a bubble

Behaviour:
- Clock and reset: single clock, clk. Reset resetN is asynchronous, active-low.
- Reset values: state IDLE, arrowX 0, arrowY ARROW_START_Y, arrowActive 0, arrowPopPulse 0, cooldown counter 0, all sticky flags 0, fireKey history register 0.
- Reset mid-flight: arrow vanishes immediately, with no pop pulse.
- Fire detect:
  - Rising edge = fireKey & ~fireKey_d.
  - Latched into fireReq only while state is IDLE.
  - fireReq clears on the startOfFrame that consumes it.
  - Edges seen in FLYING or COOLDOWN are discarded; holding the key never auto-repeats.
- Hit capture:
  - hitTopF/hitBubF: next = startOfFrame ? input : (flag | input).
  - Inputs are masked to 0 unless state is FLYING.
  - Decisions at startOfFrame use the flag value from before that cycle's update.
  - Consequence: a hit asserted in the same cycle as startOfFrame counts toward the following frame.
- Per-frame updates: every state update below happens only in a cycle with startOfFrame = 1. All outputs are registered.
- IDLE:
  - If fireReq: arrowX = min(charX + ARROW_X_OFFSET, X_MAX), computed 12-bit before clamping.
  - arrowY = ARROW_START_Y, arrowActive = 1, go to FLYING.
- FLYING, first matching rule wins:
  - hitBubF: arrowPopPulse = 1 for exactly this one cycle, arrowActive = 0, counter = COOLDOWN_FRAMES, go to COOLDOWN.
  - hitTopF, or arrowY < ARROW_SPEED: arrowActive = 0, counter = COOLDOWN_FRAMES, go to COOLDOWN. No pop.
  - Otherwise: arrowY = arrowY - ARROW_SPEED. No wrap-around is possible.
  - arrowX stays frozen during the flight, even if charX changes.
- Simultaneous top and bubble hit in one frame: bubble wins, so exactly one pop is reported.
- COOLDOWN:
  - Each frame, counter decrements.
  - When counter is 1 at startOfFrame: go to IDLE, counter = 0, arrowY = ARROW_START_Y.
  - arrowActive stays 0.
- Latency:
  - Fire edge to arrowActive: arrowActive rises the cycle after the next startOfFrame.
  - Hit to response: hit in frame N → response the cycle after frame N+1's startOfFrame.
- arrowPopPulse is never asserted in two consecutive cycles and never outside the FLYING→COOLDOWN transition.

Test Plan:
- Launch: reset, charX=100, one fireKey edge, then 1 startOfFrame → arrowActive=1, arrowX=116, arrowY=400. After 3 more frames with no hits, arrowY=376.
- Top exit, no hits: arrowY steps 400→392→…→0 over 50 frames; the next frame sees 0<8 → arrowActive=0, no pop. Exactly 4 frames later the state is IDLE, and a new fire launches again.
- Bubble hit: at arrowY=352, pulse arrowHitBubble mid-frame → at the next startOfFrame arrowPopPulse is high for exactly 1 cycle and arrowActive=0. A fireKey edge during the 4-frame cooldown produces no launch.
- Simultaneous hits: assert arrowHitTop and arrowHitBubble in the same frame → one pop pulse, state COOLDOWN. Separately, a hit coinciding with the startOfFrame cycle → acted on one frame later.
- Clamp and freeze: charX=630 → arrowX=639. charX changed to 20 mid-flight → arrowX stays 639.
- Async reset mid-flight: drop resetN between clock edges → outputs take reset values immediately. Holding fireKey high through reset release → no launch until a fresh rising edge.
